out_seq_nbuf: RTL

Parametrised output drain sequencer for the conv/fc core, the successor to the fixed two-stage output controller. It accepts finished output pixels from the kernel pipe into NBUF accumulator banks and drains them one channel per beat to output memory. Drain addresses are `oa = oc*os + wi`. Unlike its predecessor it supports any bank depth, generic widths, downstream backpressure, overflow detection, a per-sample done pulse and an s_init flush.

---
 rtl/out_seq_nbuf.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/out_seq_nbuf.sv
// Output drain sequencer: captures finished pixels into NBUF accumulator
// banks and drains them one channel per beat, with oa = oc*os + wi.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | no bank being drained; outr low
// ST_DRAIN | presenting beats from bank rd_ptr, channel oc; outr high
module out_seq_nbuf #(
    parameter int CW   = 4,
    parameter int PW   = 10,
    parameter int AW   = 12,
    parameter int NBUF = 2,
    localparam int BW  = (NBUF > 1) ? $clog2(NBUF) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          s_init_i,
    input  logic          k_fin_i,
    input  logic [CW-1:0] od_i,
    input  logic [PW-1:0] os_i,
    output logic          out_busy_o,
    output logic          update_o,
    output logic [BW-1:0] upd_bank_o,
    output logic          outr_o,
    input  logic          out_ready_i,
    output logic [BW-1:0] out_bank_o,
    output logic [CW-1:0] oc_o,
    output logic [AW-1:0] oa_o,
    output logic          done_o,
    output logic          ovf_o
);

    localparam int CNTW = $clog2(NBUF + 1);
    localparam int MW   = CW + PW;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [BW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [BW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wi_q, wi_d;
    logic [CW-1:0]   oc_q, oc_d;
    logic            ovf_q, ovf_d;
    logic            update_q, update_d;
    logic [BW-1:0]   upd_bank_q, upd_bank_d;
    logic            done_q, done_d;

    logic            full;
    logic            beat;
    logic            pix_done;
    logic            wi_last;
    logic            take;
    logic [MW-1:0]   oa_full;

    // Bank pointers wrap at NBUF, which need not be a power of two.
    function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
        if (p == BW'(NBUF - 1)) begin
            return '0;
        end
        return p + BW'(1);
    endfunction

    assign full     = (cnt_q == CNTW'(NBUF));
    assign beat     = (state_q == ST_DRAIN) && out_ready_i;
    assign pix_done = beat && (oc_q == od_i);
    assign wi_last  = (wi_q >= os_i - PW'(1));
    // s_init empties the banks first, so a coincident k_fin always fits.
    assign take     = k_fin_i && (s_init_i || !full);

    // State register and all sequencer bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wi_q       <= '0;
            oc_q       <= '0;
            ovf_q      <= 1'b0;
            update_q   <= 1'b0;
            upd_bank_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wi_q       <= wi_d;
            oc_q       <= oc_d;
            ovf_q      <= ovf_d;
            update_q   <= update_d;
            upd_bank_q <= upd_bank_d;
            done_q     <= done_d;
        end
    end

    // Bank occupancy, pointers, channel/pixel counters and event pulses.
    always_comb begin
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        oc_d       = oc_q;
        wi_d       = wi_q;
        ovf_d      = ovf_q;
        update_d   = 1'b0;
        upd_bank_d = upd_bank_q;
        done_d     = 1'b0;

        if (s_init_i) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            oc_d     = '0;
            wi_d     = '0;
            ovf_d    = 1'b0;
        end else begin
            if (k_fin_i && full) begin
                ovf_d = 1'b1;
            end
            if (pix_done) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                cnt_d    = cnt_q - CNTW'(1);
                oc_d     = '0;
                if (wi_last) begin
                    wi_d   = '0;
                    done_d = 1'b1;
                end else begin
                    wi_d = wi_q + PW'(1);
                end
            end else if (beat) begin
                oc_d = oc_q + CW'(1);
            end
        end

        // Capture is layered on top so that capture and completion in the
        // same cycle leave the occupancy unchanged while both pointers move.
        if (take) begin
            update_d   = 1'b1;
            upd_bank_d = wr_ptr_d;
            wr_ptr_d   = ptr_inc(wr_ptr_d);
            cnt_d      = cnt_d + CNTW'(1);
        end
    end

    // Next-state logic: start draining once a bank is held, stop when empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!s_init_i && (cnt_q != '0)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (s_init_i || (pix_done && (cnt_d == '0))) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign oa_full = MW'(oc_q) * MW'(os_i) + MW'(wi_q);

    assign out_busy_o = full;
    assign update_o   = update_q;
    assign upd_bank_o = upd_bank_q;
    assign outr_o     = (state_q == ST_DRAIN);
    assign out_bank_o = rd_ptr_q;
    assign oc_o       = oc_q;
    assign oa_o       = AW'(oa_full);
    assign done_o     = done_q;
    assign ovf_o      = ovf_q;

endmodule
